rc4_key_controller: RTL and testbench

//  Consumer end of the switch key interface: secret_key / key_available / key_changed.

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/rc4_key_byte_mux.sv | 26 ++
 rtl/rc4_key_controller.sv | 116 +++++++++++
 tb/tb_rc4_key_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and defaults for the RC4 key controller slice.
//   DEFAULT_KEY_BYTES : default RC4 key length in bytes
//   key_ctrl_state_t  : key controller FSM states
//   key_t             : key register type at the default key length
//   key_idx_width()   : width of a byte index for a given key length (never 0)
package rc4_pkg;

  localparam int DEFAULT_KEY_BYTES = 3;

  typedef enum logic [2:0] {
    WAIT_KEY = 3'd0,
    LATCH    = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    ABORT    = 3'd4,
    DONE     = 3'd5
  } key_ctrl_state_t;

  typedef logic [DEFAULT_KEY_BYTES*8-1:0] key_t;

  // A 1-byte key still needs a 1-bit index port.
  function automatic int key_idx_width(input int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

endpackage

// File: rtl/rc4_key_byte_mux.sv
// rc4_key_byte_mux: combinational byte selector over a packed RC4 key.
//   key       in  KEY_BYTES*8 : packed key, byte 0 is the most significant byte
//   key_index in  IDX_W       : requested byte index
//   key_byte  out 8           : selected byte, 8'h00 when key_index >= KEY_BYTES
module rc4_key_byte_mux
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
  parameter int IDX_W     = key_idx_width(KEY_BYTES)
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [IDX_W-1:0]       key_index,
  output logic [7:0]             key_byte
);

  // Out-of-range indices match no iteration and fall through to zero.
  always_comb begin
    key_byte = 8'h00;
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (key_index == IDX_W'(i)) begin
        key_byte = key[(KEY_BYTES-1-i)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_key_controller.sv
// rc4_key_controller: consumer of the switch key interface and driver of the
// RC4 core start/done/abort handshake.
//   CLOCK_50         in  1            system clock, rising edge
//   reset            in  1            synchronous active-high reset
//   secret_key       in  SW_WIDTH     key from the switch FSM
//   key_available    in  1            level, secret_key valid
//   key_changed      in  1            pulse, key is being replaced
//   key_index        in  IDX_W        byte index requested by the core
//   key_byte         out 8            key byte at key_index (combinational)
//   core_start       out 1            pulse, begin decryption
//   core_done        in  1            pulse from core, decryption finished
//   core_abort       out 1            pulse, core must return to idle
//   key_latched      out KEY_BYTES*8  current latched key
//   decrypt_complete out 1            level, core finished with key_latched
//   run_count        out 8            core_start pulses issued, mod 256
//   state_dbg        out              current FSM state
//
// Handshake: key_available is a level qualifying secret_key; key_changed is a
// single-cycle pulse during which key_available is low. core_start and
// core_abort are single-cycle Moore pulses from START and ABORT respectively,
// so they can never be high together; core_done is a single-cycle pulse and is
// only acted on in RUN.
module rc4_key_controller
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
  parameter int SW_WIDTH  = 10,
  parameter int IDX_W     = key_idx_width(KEY_BYTES)
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [SW_WIDTH-1:0]    secret_key,
  input  logic                   key_available,
  input  logic                   key_changed,
  input  logic [IDX_W-1:0]       key_index,
  output logic [7:0]             key_byte,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   core_abort,
  output logic [KEY_BYTES*8-1:0] key_latched,
  output logic                   decrypt_complete,
  output logic [7:0]             run_count,
  output key_ctrl_state_t        state_dbg
);

  localparam int KEY_W = KEY_BYTES * 8;

  key_ctrl_state_t   state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        run_cnt_q, run_cnt_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= WAIT_KEY;
      key_q     <= '0;
      run_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    key_d            = key_q;
    run_cnt_d        = run_cnt_q;
    core_start       = 1'b0;
    core_abort       = 1'b0;
    decrypt_complete = 1'b0;
    unique case (state_q)
      WAIT_KEY: begin
        if (key_available && !key_changed) state_d = LATCH;
      end
      LATCH: begin
        // Zero-extend the switch key into the full RC4 key.
        key_d   = KEY_W'(secret_key);
        state_d = START;
      end
      START: begin
        core_start = 1'b1;
        run_cnt_d  = run_cnt_q + 8'd1;
        state_d    = RUN;
      end
      RUN: begin
        // A key change wins over a simultaneous done: the result would be
        // for a key the user has already abandoned.
        if (key_changed)    state_d = ABORT;
        else if (core_done) state_d = DONE;
      end
      ABORT: begin
        core_abort = 1'b1;
        state_d    = WAIT_KEY;
      end
      DONE: begin
        decrypt_complete = 1'b1;
        if (key_changed) state_d = WAIT_KEY;
      end
      default: state_d = WAIT_KEY;
    endcase
  end

  assign key_latched = key_q;
  assign run_count   = run_cnt_q;
  assign state_dbg   = state_q;

  rc4_key_byte_mux #(
    .KEY_BYTES(KEY_BYTES),
    .IDX_W    (IDX_W)
  ) u_byte_mux (
    .key      (key_q),
    .key_index(key_index),
    .key_byte (key_byte)
  );

endmodule

// File: tb/tb_rc4_key_controller.sv
module tb_rc4_key_controller;
  import rc4_pkg::*;

  logic            CLOCK_50;
  logic            reset;
  logic [9:0]      secret_key;
  logic            key_available;
  logic            key_changed;
  logic [1:0]      key_index;
  logic [7:0]      key_byte;
  logic            core_start;
  logic            core_done;
  logic            core_abort;
  key_t            key_latched;
  logic            decrypt_complete;
  logic [7:0]      run_count;
  key_ctrl_state_t state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int abort_seen  = 0;
  int abort_mark;
  logic [23:0] exp_q[$];

  rc4_key_controller #(.KEY_BYTES(3), .SW_WIDTH(10)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .secret_key      (secret_key),
    .key_available   (key_available),
    .key_changed     (key_changed),
    .key_index       (key_index),
    .key_byte        (key_byte),
    .core_start      (core_start),
    .core_done       (core_done),
    .core_abort      (core_abort),
    .key_latched     (key_latched),
    .decrypt_complete(decrypt_complete),
    .run_count       (run_count),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Whole-run monitor: start/abort exclusivity and abort pulse counting.
  always @(negedge CLOCK_50) begin
    if (core_abort) abort_seen++;
    assert (!(core_start && core_abort)) else begin
      miscompares++;
      $display("FAIL start_abort_overlap: core_start=%0b core_abort=%0b required never both 1",
               core_start, core_abort);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    key_available = 1'b0;
    key_changed   = 1'b0;
    core_done     = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // From WAIT_KEY: present k, expect core_start two edges later, end in RUN.
  task automatic load_key(input logic [9:0] k, input string tag);
    logic [23:0] exp_key;
    secret_key    = k;
    key_available = 1'b1;
    key_changed   = 1'b0;
    exp_q.push_back({14'd0, k});
    step();
    check({tag, "_no_early_start"}, 32'(core_start), 32'd0);
    step();
    exp_key = exp_q.pop_front();
    check({tag, "_core_start"}, 32'(core_start), 32'd1);
    check({tag, "_key_latched"}, 32'(key_latched), 32'(exp_key));
    step();
  endtask

  task automatic pulse_key_changed();
    key_available = 1'b0;
    key_changed   = 1'b1;
    step();
    key_changed   = 1'b0;
  endtask

  initial begin
    secret_key    = '0;
    key_index     = '0;
    reset         = 1'b1;
    key_available = 1'b0;
    key_changed   = 1'b0;
    core_done     = 1'b0;
    step();
    step();
    step();

    // Reset state
    check("rst_state", 32'(state_dbg), 32'(WAIT_KEY));
    check("rst_key", 32'(key_latched), 32'd0);
    check("rst_run_count", 32'(run_count), 32'd0);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_abort", 32'(core_abort), 32'd0);
    check("rst_done", 32'(decrypt_complete), 32'd0);
    reset = 1'b0;
    step();
    check("idle_stays", 32'(state_dbg), 32'(WAIT_KEY));

    // 1: first key, start latency 2
    load_key(10'h2A5, "t1");
    check("t1_state_run", 32'(state_dbg), 32'(RUN));
    check("t1_run_count", 32'(run_count), 32'd1);
    check("t1_start_low", 32'(core_start), 32'd0);

    // 2: byte selection, byte 0 is the MSB byte
    key_index = 2'd0; #1 check("t2_byte0", 32'(key_byte), 32'h00);
    key_index = 2'd1; #1 check("t2_byte1", 32'(key_byte), 32'h02);
    key_index = 2'd2; #1 check("t2_byte2", 32'(key_byte), 32'hA5);
    key_index = 2'd3; #1 check("t2_byte3", 32'(key_byte), 32'h00);

    // 3: done path, held level, ignored extra done, key change restarts
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("t3_dc_set", 32'(decrypt_complete), 32'd1);
    step();
    check("t3_dc_held", 32'(decrypt_complete), 32'd1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("t3_done_ignored", 32'(state_dbg), 32'(DONE));
    pulse_key_changed();
    check("t3_dc_drop", 32'(decrypt_complete), 32'd0);
    check("t3_back_wait", 32'(state_dbg), 32'(WAIT_KEY));
    load_key(10'h0F3, "t3");
    check("t3_run_count", 32'(run_count), 32'd2);
    key_index = 2'd2; #1 check("t3_byte2", 32'(key_byte), 32'hF3);

    // 4: key change wins over simultaneous done
    do_reset();
    load_key(10'h2A5, "t4a");
    abort_mark    = abort_seen;
    key_available = 1'b0;
    key_changed   = 1'b1;
    core_done     = 1'b1;
    step();
    key_changed   = 1'b0;
    core_done     = 1'b0;
    check("t4_abort", 32'(core_abort), 32'd1);
    check("t4_dc_low", 32'(decrypt_complete), 32'd0);
    check("t4_key_kept", 32'(key_latched), 32'h0002A5);
    secret_key    = 10'h155;
    key_available = 1'b1;
    step();
    check("t4_abort_one_cycle", 32'(core_abort), 32'd0);
    check("t4_wait", 32'(state_dbg), 32'(WAIT_KEY));
    load_key(10'h155, "t4b");
    check("t4_run_count", 32'(run_count), 32'd2);
    check("t4_dc_still_low", 32'(decrypt_complete), 32'd0);
    check("t4_abort_count", 32'(abort_seen - abort_mark), 32'd1);

    // 5: 256 restarts wrap run_count, mixing abort and done paths
    do_reset();
    abort_mark = abort_seen;
    for (int i = 0; i < 256; i++) begin
      load_key(10'($urandom_range(0, 1023)), "t5");
      if (i == 254) check("t5_run_count_255", 32'(run_count), 32'd255);
      if (i % 2 == 1) begin
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        pulse_key_changed();
      end else begin
        pulse_key_changed();
        step();
      end
    end
    check("t5_run_count_wrap", 32'(run_count), 32'd0);
    check("t5_abort_count", 32'(abort_seen - abort_mark), 32'd128);

    // 6: reset in RUN drops everything without an abort
    do_reset();
    load_key(10'h2A5, "t6");
    check("t6_in_run", 32'(state_dbg), 32'(RUN));
    abort_mark = abort_seen;
    reset = 1'b1;
    step();
    reset         = 1'b0;
    key_available = 1'b0;
    check("t6_state", 32'(state_dbg), 32'(WAIT_KEY));
    check("t6_key", 32'(key_latched), 32'd0);
    check("t6_run_count", 32'(run_count), 32'd0);
    check("t6_start", 32'(core_start), 32'd0);
    check("t6_abort", 32'(core_abort), 32'd0);
    check("t6_dc", 32'(decrypt_complete), 32'd0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("t6_done_ignored", 32'(state_dbg), 32'(WAIT_KEY));
    check("t6_dc_after", 32'(decrypt_complete), 32'd0);
    check("t6_no_abort", 32'(abort_seen - abort_mark), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
